// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide sequencer: command encoding and FSM states.
package md_pkg;

    localparam int unsigned MD_OP_W   = 3;
    localparam int unsigned MD_DATA_W = 32;

    localparam logic [MD_OP_W-1:0] MD_NONE  = 3'd0;
    localparam logic [MD_OP_W-1:0] MD_MULT  = 3'd1;
    localparam logic [MD_OP_W-1:0] MD_MULTU = 3'd2;
    localparam logic [MD_OP_W-1:0] MD_DIV   = 3'd3;
    localparam logic [MD_OP_W-1:0] MD_DIVU  = 3'd4;
    localparam logic [MD_OP_W-1:0] MD_MTHI  = 3'd5;
    localparam logic [MD_OP_W-1:0] MD_MTLO  = 3'd6;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } md_state_e;

    // True for every real md command; NONE and the reserved code 7 are inert.
    function automatic logic md_op_active(input logic [MD_OP_W-1:0] op);
        return (op >= MD_MULT) && (op <= MD_MTLO);
    endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational 32x32 signed/unsigned multiply and divide producing {hi,lo}.
module md_arith
    import md_pkg::*;
(
    input  logic [MD_OP_W-1:0]   i_op,
    input  logic [MD_DATA_W-1:0] i_a,
    input  logic [MD_DATA_W-1:0] i_b,
    input  logic [MD_DATA_W-1:0] i_hi,
    input  logic [MD_DATA_W-1:0] i_lo,
    output logic [MD_DATA_W-1:0] o_hi_c,
    output logic [MD_DATA_W-1:0] o_lo_c
);

    logic [2*MD_DATA_W-1:0] w_prod_s;
    logic [2*MD_DATA_W-1:0] w_prod_u;
    logic                   w_b_zero;
    logic                   w_neg_a;
    logic                   w_neg_b;
    logic [MD_DATA_W-1:0]   w_b_safe;
    logic [MD_DATA_W-1:0]   w_mag_a;
    logic [MD_DATA_W-1:0]   w_mag_b;
    logic [MD_DATA_W-1:0]   w_q_u;
    logic [MD_DATA_W-1:0]   w_r_u;
    logic [MD_DATA_W-1:0]   w_q_mag;
    logic [MD_DATA_W-1:0]   w_r_mag;

    // Low 64 bits of a product of sign-extended operands are the exact signed product.
    assign w_prod_s = {{MD_DATA_W{i_a[MD_DATA_W-1]}}, i_a} * {{MD_DATA_W{i_b[MD_DATA_W-1]}}, i_b};
    assign w_prod_u = {{MD_DATA_W{1'b0}}, i_a} * {{MD_DATA_W{1'b0}}, i_b};

    // Divisor forced to 1 on zero so the dividers never see a zero; the result is discarded anyway.
    assign w_b_zero = (i_b == '0);
    assign w_b_safe = w_b_zero ? MD_DATA_W'(1) : i_b;
    assign w_neg_a  = i_a[MD_DATA_W-1];
    assign w_neg_b  = i_b[MD_DATA_W-1];
    assign w_mag_a  = w_neg_a ? (~i_a + MD_DATA_W'(1)) : i_a;
    assign w_mag_b  = w_b_zero ? MD_DATA_W'(1) : (w_neg_b ? (~i_b + MD_DATA_W'(1)) : i_b);

    // Signed divide via magnitudes; 0x80000000/-1 wraps naturally to quotient 0x80000000.
    assign w_q_u   = i_a / w_b_safe;
    assign w_r_u   = i_a % w_b_safe;
    assign w_q_mag = w_mag_a / w_mag_b;
    assign w_r_mag = w_mag_a % w_mag_b;

    // Select the result; divide by zero and non-arith ops return the current HI/LO.
    always_comb begin
        o_hi_c = i_hi;
        o_lo_c = i_lo;
        case (i_op)
            MD_MULT:  {o_hi_c, o_lo_c} = w_prod_s;
            MD_MULTU: {o_hi_c, o_lo_c} = w_prod_u;
            MD_DIV: begin
                if (!w_b_zero) begin
                    o_lo_c = (w_neg_a ^ w_neg_b) ? (~w_q_mag + MD_DATA_W'(1)) : w_q_mag;
                    o_hi_c = w_neg_a ? (~w_r_mag + MD_DATA_W'(1)) : w_r_mag;
                end
            end
            MD_DIVU: begin
                if (!w_b_zero) begin
                    o_lo_c = w_q_u;
                    o_hi_c = w_r_u;
                end
            end
            default: begin
                o_hi_c = i_hi;
                o_lo_c = i_lo;
            end
        endcase
    end

endmodule

// File: rtl/md_sched.sv
// Multi-cycle mult/div sequencer owning architectural HI/LO and the md-hazard stall.
module md_sched
    import md_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 E_start,
    input  logic [MD_OP_W-1:0]   E_op,
    input  logic [MD_DATA_W-1:0] E_A,
    input  logic [MD_DATA_W-1:0] E_B,
    input  logic                 D_md_use,
    output logic                 busy,
    output logic                 stall_md,
    output logic [MD_DATA_W-1:0] HI,
    output logic [MD_DATA_W-1:0] LO
);

    localparam int unsigned MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

    md_state_e            r_state, w_state_n;
    logic [CNT_W-1:0]     r_cnt, w_cnt_n;
    logic [MD_DATA_W-1:0] r_hi, w_hi_n;
    logic [MD_DATA_W-1:0] r_lo, w_lo_n;
    logic [MD_DATA_W-1:0] r_pend_hi, w_pend_hi_n;
    logic [MD_DATA_W-1:0] r_pend_lo, w_pend_lo_n;
    logic [MD_DATA_W-1:0] w_ar_hi;
    logic [MD_DATA_W-1:0] w_ar_lo;

    md_arith u_arith (
        .i_op   (E_op),
        .i_a    (E_A),
        .i_b    (E_B),
        .i_hi   (r_hi),
        .i_lo   (r_lo),
        .o_hi_c (w_ar_hi),
        .o_lo_c (w_ar_lo)
    );

    // State, counter, HI/LO and pending-result registers; reset discards any op in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_pend_hi <= '0;
            r_pend_lo <= '0;
        end else begin
            r_state   <= w_state_n;
            r_cnt     <= w_cnt_n;
            r_hi      <= w_hi_n;
            r_lo      <= w_lo_n;
            r_pend_hi <= w_pend_hi_n;
            r_pend_lo <= w_pend_lo_n;
        end
    end

    // Next-state: latch result at issue, count down in RUN, commit on the last busy edge.
    always_comb begin
        w_state_n   = r_state;
        w_cnt_n     = r_cnt;
        w_hi_n      = r_hi;
        w_lo_n      = r_lo;
        w_pend_hi_n = r_pend_hi;
        w_pend_lo_n = r_pend_lo;
        case (r_state)
            S_IDLE: begin
                if (E_start) begin
                    case (E_op)
                        MD_MULT, MD_MULTU: begin
                            w_pend_hi_n = w_ar_hi;
                            w_pend_lo_n = w_ar_lo;
                            w_cnt_n     = CNT_W'(MULT_CYCLES);
                            w_state_n   = S_RUN;
                        end
                        MD_DIV, MD_DIVU: begin
                            w_pend_hi_n = w_ar_hi;
                            w_pend_lo_n = w_ar_lo;
                            w_cnt_n     = CNT_W'(DIV_CYCLES);
                            w_state_n   = S_RUN;
                        end
                        MD_MTHI: w_hi_n = E_A;
                        MD_MTLO: w_lo_n = E_A;
                        default: w_state_n = S_IDLE;
                    endcase
                end
            end
            S_RUN: begin
                w_cnt_n = r_cnt - CNT_W'(1);
                if (r_cnt == CNT_W'(1)) begin
                    w_hi_n    = r_pend_hi;
                    w_lo_n    = r_pend_lo;
                    w_state_n = S_IDLE;
                end
            end
            default: begin
                w_state_n = S_IDLE;
                w_cnt_n   = '0;
            end
        endcase
    end

    // Outputs: busy and HI/LO come straight from registers; stall is the only combinational path.
    assign busy     = (r_state == S_RUN);
    assign HI       = r_hi;
    assign LO       = r_lo;
    assign stall_md = D_md_use & (busy | (E_start & md_op_active(E_op)));

endmodule

// File: doc/md_sched.md
Name: md_sched

Overview:
- Multi-cycle multiply/divide sequencer and HI/LO owner for the 5-stage MIPS pipeline.
- Accepts one mult/div/mthi/mtlo command per cycle from the E stage and sequences the multi-cycle operation.
- Holds the architectural HI/LO registers, whose values flow into the M/W pipeline registers as the HILO field.
- Drives the md-hazard stall request to the hazard unit, so a D-stage md instruction cannot advance while the unit is occupied.

Parameters:
- MULT_CYCLES, 5: busy cycles for MULT/MULTU; must be ≥1.
- DIV_CYCLES, 10: busy cycles for DIV/DIVU; must be ≥1.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- E_start  in  1  E-stage instruction issues an md command this cycle.
- E_op  in  3  command: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO; 7 is reserved and treated as NONE.
- E_A  in  32  rs operand (forwarded).
- E_B  in  32  rt operand (forwarded).
- D_md_use  in  1  D-stage instruction is any of mult/div/mfhi/mflo/mthi/mtlo.
- busy  out  1  multi-cycle operation in flight.
- stall_md  out  1  md-hazard stall request to the hazard unit.
- HI  out  32  architectural HI.
- LO  out  32  architectural LO.

Behaviour:
- Reset (reset=0, async): state=IDLE, cnt=0, busy=0, HI=0, LO=0, pending results=0. An operation in flight is discarded and never commits.
- States: IDLE, RUN. busy = (state==RUN), registered.
- IDLE + E_start + op MULT/MULTU/DIV/DIVU, at edge t0:
  - Compute the result combinationally from E_A/E_B and latch it into pend_hi/pend_lo.
  - cnt <= MULT_CYCLES or DIV_CYCLES; state <= RUN.
- RUN, each edge: cnt <= cnt-1. At the edge where cnt==1: HI/LO <= pend_hi/pend_lo and state <= IDLE.
- Net timing: busy is high for exactly N cycles (t0+1 .. t0+N). New HI/LO become visible in the same cycle busy falls.
- MTHI/MTLO with E_start in IDLE: HI or LO <= E_A at the next edge; busy stays 0. Single-cycle, no stall beyond the E_start cycle.
- Arithmetic:
  - MULT: signed 64-bit product of E_A*E_B, HI = bits [63:32], LO = bits [31:0].
  - MULTU: same as MULT, unsigned operands.
  - DIV: LO = quotient truncated toward zero; HI = remainder carrying the dividend's sign.
  - DIVU: unsigned quotient/remainder.
  - Divide by zero (E_B==0): operation still occupies DIV_CYCLES; at commit HI/LO are left unchanged (pend values are loaded from the current HI/LO at start).
  - DIV 0x80000000 / -1: LO=0x80000000, HI=0.
- stall_md = D_md_use & (busy | (E_start & E_op≠NONE)). Combinational from busy and inputs, no other combinational path.
- The hazard unit guarantees E_start never coincides with busy. If it does, the command is ignored: no state change, no HI/LO write. The bench flags this with an assertion.
- E_op NONE/reserved with E_start=1: no effect.
- cnt width = $clog2(max(MULT_CYCLES,DIV_CYCLES)+1).
- No flush input: md ops are never squashed once in E (branch delay slot semantics).

Decomposition:
- Shared package `md_pkg`: E_op encoding localparams (MD_NONE..MD_MTLO), state encoding (S_IDLE, S_RUN).
- The op decoder in the control unit imports `md_pkg`.
- One natural sub-module, `md_arith`: purely combinational 32×32 signed/unsigned mul and div producing {hi,lo}, with the div-by-zero and overflow rules above.
- The FSM, counter, HI/LO registers and stall logic stay in md_sched.

Test Plan:
- MULT E_A=0xFFFFFFFD (-3), E_B=5, E_start 1 cycle → busy high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFF1. HI/LO unchanged while busy.
- DIVU E_A=100, E_B=7 → busy 10 cycles; then LO=14, HI=2. DIV E_A=-7, E_B=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIV with E_B=0 after MTHI 0x1234 / MTLO 0x5678 → busy 10 cycles; HI=0x1234, LO=0x5678 retained.
- stall: MULT issued while D_md_use=1 → stall_md=1 in the issue cycle and all 5 busy cycles, 0 in the first cycle busy=0. D_md_use=0 → stall_md=0 throughout.
- MTLO E_A=0xDEADBEEF in IDLE → LO=0xDEADBEEF next edge; busy never asserts.
- Reset pulled low at busy cycle 3 of MULTU 0xFFFFFFFF×2 → busy, HI and LO read 0 immediately (async). After release, no late commit occurs and HI/LO stay 0.
